// File: rtl/axis_data_packer_mc.sv
// axis_data_packer_mc
//
// Packs one fixed-size record from one of NUM_CH input channels into an AXI
// stream packet. Each packet carries a 16-bit header in front of the record:
//   hdr[7:0]   per-channel sequence number (wraps at 256)
//   hdr[11:8]  channel index
//   hdr[15:12] zero
// The packet {record, hdr} goes out little-endian over ceil((DATA_WIDTH+16) /
// AXIS_DATA_WIDTH) beats. Unused bits in the last beat are zero, and tkeep
// marks only the bytes that are in use.
//
// Ports
//   m_axis_c2h_aclk     clock (rising edge)
//   m_axis_c2h_aresetn  asynchronous active-low reset
//   en                  accept enable; a packet already in flight is not aborted
//   seq_clr             synchronous clear of all sequence counters
//   s_data/s_valid      per-channel record and valid
//   s_ready             per-channel accept (combinational, at most one bit high)
//   m_axis_c2h_*        AXI stream master
//   busy                a packet is held or being sent
//   cur_ch              channel of the most recently latched packet
module axis_data_packer_mc #(
  parameter int DATA_WIDTH      = 4064,
  parameter int AXIS_DATA_WIDTH = 512,
  parameter int NUM_CH          = 2
) (
  input  logic                           m_axis_c2h_aclk,
  input  logic                           m_axis_c2h_aresetn,
  input  logic                           en,
  input  logic                           seq_clr,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   s_data,
  input  logic [NUM_CH-1:0]              s_valid,
  output logic [NUM_CH-1:0]              s_ready,
  output logic [AXIS_DATA_WIDTH-1:0]     m_axis_c2h_tdata,
  output logic [AXIS_DATA_WIDTH/8-1:0]   m_axis_c2h_tkeep,
  output logic                           m_axis_c2h_tlast,
  output logic                           m_axis_c2h_tvalid,
  input  logic                           m_axis_c2h_tready,
  output logic                           busy,
  output logic [3:0]                     cur_ch
);

  localparam int HDR_W      = 16;
  localparam int PKT_W      = DATA_WIDTH + HDR_W;
  localparam int NBEATS     = (PKT_W + AXIS_DATA_WIDTH - 1) / AXIS_DATA_WIDTH;
  localparam int BUF_W      = NBEATS * AXIS_DATA_WIDTH;
  localparam int KEEP_W     = AXIS_DATA_WIDTH / 8;
  localparam int LAST_BYTES = (PKT_W - (NBEATS - 1) * AXIS_DATA_WIDTH + 7) / 8;
  localparam int BEAT_W     = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  localparam logic [KEEP_W-1:0] KEEP_ALL  = {KEEP_W{1'b1}};
  localparam logic [KEEP_W-1:0] KEEP_LAST = KEEP_ALL >> (KEEP_W - LAST_BYTES);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

  typedef enum logic {S_IDLE = 1'b0, S_SEND = 1'b1} state_t;

  state_t              state_q;
  logic [3:0]          ptr_q;
  logic [3:0]          cur_ch_q;
  logic [BEAT_W-1:0]   beat_q;
  logic [BUF_W-1:0]    pkt_q;
  logic                tvalid_q;
  logic                tlast_q;
  logic [KEEP_W-1:0]   tkeep_q;
  logic [7:0]          seq_q [NUM_CH];

  logic [15:0]           vld_ext;
  logic [4:0]            cand;
  logic [3:0]            grant_idx;
  logic                  grant_vld;
  logic                  accept;
  logic                  pkt_done;
  logic [3:0]            ptr_d;
  logic [7:0]            seq_sel;
  logic [DATA_WIDTH-1:0] rec_sel;
  logic [BUF_W-1:0]      pkt_d;

  // Round-robin search starting at ptr_q, which points one past the last grant.
  assign vld_ext = 16'(s_valid);

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = {1'b0, ptr_q} + 5'(k);
      if (cand >= 5'(NUM_CH)) cand = cand - 5'(NUM_CH);
      if (!grant_vld && vld_ext[cand[3:0]]) begin
        grant_vld = 1'b1;
        grant_idx = cand[3:0];
      end
    end
  end

  // Reset gates the accept so s_ready is forced low while reset is held.
  assign accept = m_axis_c2h_aresetn && (state_q == S_IDLE) && en && grant_vld;

  always_comb begin
    s_ready = '0;
    for (int i = 0; i < NUM_CH; i++) s_ready[i] = accept && (grant_idx == 4'(i));
  end

  assign ptr_d = (grant_idx == 4'(NUM_CH - 1)) ? 4'd0 : grant_idx + 4'd1;

  always_comb begin
    seq_sel = '0;
    rec_sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant_idx == 4'(i)) begin
        seq_sel = seq_q[i];
        rec_sel = s_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Whole packet image, zero padded up to a whole number of beats.
  always_comb begin
    pkt_d                         = '0;
    pkt_d[HDR_W-1:0]              = {4'h0, grant_idx, seq_sel};
    pkt_d[HDR_W +: DATA_WIDTH]    = rec_sel;
  end

  assign pkt_done = (state_q == S_SEND) && m_axis_c2h_tready && (beat_q == LAST_BEAT);

  always_ff @(posedge m_axis_c2h_aclk or negedge m_axis_c2h_aresetn) begin
    if (!m_axis_c2h_aresetn) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      cur_ch_q <= '0;
      beat_q   <= '0;
      pkt_q    <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tkeep_q  <= '0;
      for (int i = 0; i < NUM_CH; i++) seq_q[i] <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            state_q  <= S_SEND;
            pkt_q    <= pkt_d;
            cur_ch_q <= grant_idx;
            ptr_q    <= ptr_d;
            beat_q   <= '0;
            tvalid_q <= 1'b1;
            tlast_q  <= (NBEATS == 1);
            tkeep_q  <= (NBEATS == 1) ? KEEP_LAST : KEEP_ALL;
          end
        end
        S_SEND: begin
          if (m_axis_c2h_tready) begin
            if (beat_q == LAST_BEAT) begin
              state_q  <= S_IDLE;
              tvalid_q <= 1'b0;
              tlast_q  <= 1'b0;
              tkeep_q  <= '0;
            end else begin
              // The buffer shifts down so the current beat is always the low slice.
              beat_q   <= beat_q + BEAT_W'(1);
              pkt_q    <= pkt_q >> AXIS_DATA_WIDTH;
              tlast_q  <= ((beat_q + BEAT_W'(1)) == LAST_BEAT);
              tkeep_q  <= ((beat_q + BEAT_W'(1)) == LAST_BEAT) ? KEEP_LAST : KEEP_ALL;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase

      // Clear has priority over the completion increment.
      for (int i = 0; i < NUM_CH; i++) begin
        if (seq_clr) seq_q[i] <= '0;
        else if (pkt_done && (cur_ch_q == 4'(i))) seq_q[i] <= seq_q[i] + 8'd1;
      end
    end
  end

  assign m_axis_c2h_tdata  = pkt_q[AXIS_DATA_WIDTH-1:0];
  assign m_axis_c2h_tkeep  = tkeep_q;
  assign m_axis_c2h_tlast  = tlast_q;
  assign m_axis_c2h_tvalid = tvalid_q;
  assign busy              = (state_q == S_SEND);
  assign cur_ch            = cur_ch_q;

endmodule

// File: tb/tb_axis_data_packer_mc.sv
`timescale 1ns/1ps
module tb_axis_data_packer_mc;

  localparam int DW    = 4064;
  localparam int AW    = 512;
  localparam int NCH   = 2;
  localparam int KW    = AW / 8;
  localparam int NB    = (DW + 16 + AW - 1) / AW;
  localparam int LASTB = (DW + 16 - (NB - 1) * AW + 7) / 8;

  logic              clk = 1'b0;
  logic              rst_n, en, seq_clr, tready;
  logic [NCH*DW-1:0] s_data;
  logic [NCH-1:0]    s_valid, s_ready;
  logic [AW-1:0]     tdata;
  logic [KW-1:0]     tkeep;
  logic              tlast, tvalid, busy;
  logic [3:0]        cur_ch;

  always #5 clk = ~clk;

  axis_data_packer_mc #(.DATA_WIDTH(DW), .AXIS_DATA_WIDTH(AW), .NUM_CH(NCH)) dut (
    .m_axis_c2h_aclk   (clk),
    .m_axis_c2h_aresetn(rst_n),
    .en                (en),
    .seq_clr           (seq_clr),
    .s_data            (s_data),
    .s_valid           (s_valid),
    .s_ready           (s_ready),
    .m_axis_c2h_tdata  (tdata),
    .m_axis_c2h_tkeep  (tkeep),
    .m_axis_c2h_tlast  (tlast),
    .m_axis_c2h_tvalid (tvalid),
    .m_axis_c2h_tready (tready),
    .busy              (busy),
    .cur_ch            (cur_ch)
  );

  typedef struct packed {
    logic [AW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic          first;
  } beat_t;

  beat_t       sbq[$];
  logic [15:0] hdr_log[$];
  int          vectors = 0, miscompares = 0;
  int          acc_cnt = 0, pkt_done = 0, hs_cnt = 0;
  logic [KW-1:0] last_keep_seen;
  logic [AW-1:0] last_beat0;

  // Reference model state, describing the DUT after the coming rising edge.
  bit         m_send = 0;
  int         m_ptr = 0, m_cur = 0;
  logic [7:0] m_seq [NCH];

  function automatic int rr_pick(input logic [NCH-1:0] v, input int ptr);
    for (int k = 0; k < NCH; k++)
      if (v[(ptr + k) % NCH] === 1'b1) return (ptr + k) % NCH;
    return -1;
  endfunction

  function automatic logic [KW-1:0] keep_last();
    logic [KW-1:0] r;
    r = '0;
    for (int i = 0; i < LASTB; i++) r[i] = 1'b1;
    return r;
  endfunction

  // Scoreboard: expected beats are queued on accept, checked on every valid cycle.
  always @(negedge clk) begin
    int g;
    logic [NCH-1:0] exp_rdy;
    logic [NB*AW-1:0] pkt;
    beat_t b;
    if (rst_n !== 1'b1) begin
      m_send = 0; m_ptr = 0; m_cur = 0;
      foreach (m_seq[i]) m_seq[i] = 8'd0;
      sbq.delete();
      vectors++;
      if (tvalid !== 1'b0 || s_ready !== '0 || busy !== 1'b0 || cur_ch !== 4'd0 || tlast !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_outputs: tvalid=%b s_ready=%b busy=%b cur_ch=%0d tlast=%b, required all 0",
                 tvalid, s_ready, busy, cur_ch, tlast);
      end
    end else begin
      vectors++;
      if (tvalid !== m_send || busy !== m_send || cur_ch !== 4'(m_cur)) begin
        miscompares++;
        $display("FAIL ctrl: tvalid=%b busy=%b cur_ch=%0d, required tvalid=%b busy=%b cur_ch=%0d",
                 tvalid, busy, cur_ch, m_send, m_send, m_cur);
      end
      g = -1;
      exp_rdy = '0;
      if (!m_send && en === 1'b1) g = rr_pick(s_valid, m_ptr);
      if (g >= 0) exp_rdy[g] = 1'b1;
      vectors++;
      if (s_ready !== exp_rdy) begin
        miscompares++;
        $display("FAIL s_ready: got %b, required %b", s_ready, exp_rdy);
      end
      if (tvalid === 1'b1) begin
        vectors++;
        if (sbq.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_beat: tvalid=1 with no packet outstanding, required tvalid=0");
        end else begin
          b = sbq[0];
          if (tdata !== b.data || tkeep !== b.keep || tlast !== b.last) begin
            miscompares++;
            $display("FAIL beat: tdata=%h tkeep=%h tlast=%b, required tdata=%h tkeep=%h tlast=%b",
                     tdata, tkeep, tlast, b.data, b.keep, b.last);
          end
          if (tready === 1'b1) begin
            void'(sbq.pop_front());
            hs_cnt++;
            if (b.first) begin
              hdr_log.push_back(tdata[15:0]);
              last_beat0 = tdata;
            end
            if (b.last) begin
              last_keep_seen = tkeep;
              m_send = 0;
              pkt_done++;
              m_seq[m_cur] = m_seq[m_cur] + 8'd1;
            end
          end
        end
      end
      if (g >= 0) begin
        pkt = '0;
        pkt[15:0] = {4'h0, 4'(g), m_seq[g]};
        pkt[16 +: DW] = s_data[g*DW +: DW];
        for (int k = 0; k < NB; k++) begin
          b.data  = pkt[k*AW +: AW];
          b.keep  = (k == NB - 1) ? keep_last() : '1;
          b.last  = (k == NB - 1);
          b.first = (k == 0);
          sbq.push_back(b);
        end
        m_send = 1; m_cur = g; m_ptr = (g + 1) % NCH;
        acc_cnt++;
      end
      if (seq_clr === 1'b1) foreach (m_seq[i]) m_seq[i] = 8'd0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_data();
    for (int i = 0; i < NCH * DW / 8; i++) s_data[i*8 +: 8] = 8'($urandom);
  endtask

  task automatic run_pkts(input logic [NCH-1:0] mask, input int n, input bit toggle);
    int a0, d0;
    bit done;
    a0 = acc_cnt; d0 = pkt_done; done = 0;
    s_valid = mask;
    for (int c = 0; c < n * 40 + 40; c++) begin
      tick();
      if (toggle) tready = ~tready;
      if (acc_cnt - a0 >= n) s_valid = '0;
      if (pkt_done - d0 >= n) begin
        done = 1;
        break;
      end
    end
    s_valid = '0;
    tready  = 1'b1;
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL packets_done: got %0d, required %0d", pkt_done - d0, n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; seq_clr = 1'b0; tready = 1'b1;
    s_data = '0; s_valid = '1;
    repeat (3) tick();
    vectors++;
    if (tvalid !== 1'b0 || tlast !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: tvalid=%b tlast=%b busy=%b, required 0 0 0", tvalid, tlast, busy);
    end
    vectors++;
    if (tdata !== '0 || tkeep !== '0) begin
      miscompares++;
      $display("FAIL reset_data: tdata=%h tkeep=%h, required 0", tdata, tkeep);
    end
    vectors++;
    if (s_ready !== '0 || cur_ch !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_ready: s_ready=%b cur_ch=%0d, required 0 0", s_ready, cur_ch);
    end
    s_valid = '0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int h0;
    logic [15:0] h;
    rand_data();
    s_data[7:0] = 8'hAB;
    h0 = hs_cnt;
    run_pkts(2'b01, 1, 1'b0);
    vectors++;
    if (last_beat0[15:0] !== 16'h0000 || last_beat0[23:16] !== 8'hAB) begin
      miscompares++;
      $display("FAIL single_beat0: hdr=%h rec_lsb=%h, required 0000 ab", last_beat0[15:0], last_beat0[23:16]);
    end
    vectors++;
    if (last_keep_seen !== 64'h3FFF_FFFF_FFFF_FFFF) begin
      miscompares++;
      $display("FAIL single_last_keep: got %h, required 3fffffffffffffff", last_keep_seen);
    end
    vectors++;
    if (hs_cnt - h0 !== 8) begin
      miscompares++;
      $display("FAIL single_beats: got %0d, required 8", hs_cnt - h0);
    end
    run_pkts(2'b01, 1, 1'b0);
    h = hdr_log[$];
    vectors++;
    if (h !== 16'h0001) begin
      miscompares++;
      $display("FAIL single_seq: hdr=%h, required 0001", h);
    end
  endtask

  task automatic test_round_robin();
    logic [15:0] exp_h [6];
    int base;
    exp_h = '{16'h0100, 16'h0000, 16'h0101, 16'h0001, 16'h0102, 16'h0002};
    seq_clr = 1'b1; tick(); seq_clr = 1'b0;
    rand_data();
    base = hdr_log.size();
    run_pkts(2'b11, 6, 1'b0);
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (base + i >= hdr_log.size() || hdr_log[base + i] !== exp_h[i]) begin
        miscompares++;
        $display("FAIL rr_hdr[%0d]: got %h, required %h", i,
                 (base + i < hdr_log.size()) ? hdr_log[base + i] : 16'hxxxx, exp_h[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int h0;
    rand_data();
    h0 = hs_cnt;
    run_pkts(2'b01, 1, 1'b1);
    vectors++;
    if (hs_cnt - h0 !== 8 || sbq.size() !== 0) begin
      miscompares++;
      $display("FAIL stall_beats: handshakes=%0d left=%0d, required 8 0", hs_cnt - h0, sbq.size());
    end
  endtask

  task automatic test_seq_wrap();
    int base;
    bit seen;
    logic [15:0] h;
    seq_clr = 1'b1; tick(); seq_clr = 1'b0;
    rand_data();
    base = hdr_log.size();
    run_pkts(2'b10, 257, 1'b0);
    vectors++;
    if (base + 256 >= hdr_log.size() || hdr_log[base + 255] !== 16'h01FF || hdr_log[base + 256] !== 16'h0100) begin
      miscompares++;
      $display("FAIL seq_wrap: log size %0d from %0d, required hdr 01ff then 0100", hdr_log.size(), base);
    end
    // Pulse seq_clr on the same edge as a packet's final handshake.
    s_valid = 2'b10;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (tvalid === 1'b1 && tlast === 1'b1) begin
        seen = 1;
        break;
      end
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL clr_wait: last beat not seen, required within 40 cycles");
    end
    seq_clr = 1'b1; tick(); seq_clr = 1'b0;
    h = hdr_log[$];
    vectors++;
    if (h !== 16'h0101) begin
      miscompares++;
      $display("FAIL clr_inflight_hdr: got %h, required 0101", h);
    end
    run_pkts(2'b10, 1, 1'b0);
    h = hdr_log[$];
    vectors++;
    if (h !== 16'h0100) begin
      miscompares++;
      $display("FAIL clr_next_hdr: got %h, required 0100", h);
    end
  endtask

  task automatic test_reset_mid();
    int h0, a0, base;
    logic [15:0] h;
    rand_data();
    h0 = hs_cnt; a0 = acc_cnt;
    s_valid = 2'b01;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (acc_cnt > a0) s_valid = '0;
      if (hs_cnt - h0 >= 3) break;
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (tvalid !== 1'b0 || busy !== 1'b0 || tlast !== 1'b0 || tdata !== '0 || tkeep !== '0) begin
      miscompares++;
      $display("FAIL midreset_now: tvalid=%b busy=%b tlast=%b tkeep=%h, required all 0", tvalid, busy, tlast, tkeep);
    end
    s_valid = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    vectors++;
    if (tvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_after: tvalid=%b, required 0", tvalid);
    end
    base = hdr_log.size();
    run_pkts(2'b01, 1, 1'b0);
    h = (hdr_log.size() > base) ? hdr_log[base] : 16'hFFFF;
    vectors++;
    if (h !== 16'h0000) begin
      miscompares++;
      $display("FAIL midreset_fresh_hdr: got %h, required 0000", h);
    end
  endtask

  task automatic test_enable();
    int a0, d0;
    en = 1'b0;
    s_valid = 2'b11;
    for (int c = 0; c < 10; c++) begin
      tick();
      vectors++;
      if (s_ready !== '0 || tvalid !== 1'b0) begin
        miscompares++;
        $display("FAIL en_off: s_ready=%b tvalid=%b, required 00 0", s_ready, tvalid);
      end
    end
    a0 = acc_cnt; d0 = pkt_done;
    en = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (acc_cnt > a0) break;
    end
    en = 1'b0;
    s_valid = '0;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL en_drop_busy: busy=%b, required 1", busy);
    end
    for (int c = 0; c < 40; c++) begin
      tick();
      if (pkt_done > d0) break;
    end
    vectors++;
    if (pkt_done - d0 !== 1 || sbq.size() !== 0) begin
      miscompares++;
      $display("FAIL en_drop_complete: packets=%0d left=%0d, required 1 0", pkt_done - d0, sbq.size());
    end
    en = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_seq_wrap();
    test_reset_mid();
    test_enable();
    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axis_data_packer_mc.md
AXIS_DATA_PACKER_MC -- requirements
Module: axis_data_packer_mc

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 4064, giving the payload bits per channel record; it SHALL be a multiple of 8.
REQ-002 The block SHALL have parameter AXIS_DATA_WIDTH, default 512, giving the AXIS beat width; it SHALL be a multiple of 8 and at least 32.
REQ-003 The block SHALL have parameter NUM_CH, default 2, giving the number of input channels, range 1..16.
REQ-004 Port m_axis_c2h_aclk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 Port m_axis_c2h_aresetn, input, 1 bit: reset, asynchronous and active-low.
REQ-006 Port en, input, 1 bit: synchronous enable; while 0 no new record is accepted.
REQ-007 Port seq_clr, input, 1 bit: synchronous clear of all sequence counters.
REQ-008 Port s_data, input, NUM_CH*DATA_WIDTH: channel i record is bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 Port s_valid, input, NUM_CH: per-channel record valid.
REQ-010 Port s_ready, output, NUM_CH: per-channel record accept.
REQ-011 Ports m_axis_c2h_tdata (AXIS_DATA_WIDTH), m_axis_c2h_tkeep (AXIS_DATA_WIDTH/8), m_axis_c2h_tlast (1), m_axis_c2h_tvalid (1): outputs; m_axis_c2h_tready (1): input.
REQ-012 Port busy, output, 1 bit: high while a packet is held or being sent; port cur_ch, output, 4 bits: channel of the current packet.

Function
REQ-013 Packet SHALL be the concatenation {record, hdr}, sent little-endian: bit 0 of beat 0 is bit 0 of hdr.
REQ-014 hdr SHALL be 16 bits: [7:0] = the channel's sequence number, [11:8] = channel index, [15:12] = 0.
REQ-015 Beat count N SHALL be ceil((DATA_WIDTH+16)/AXIS_DATA_WIDTH); bits beyond DATA_WIDTH+16 in the last beat SHALL be 0.
REQ-016 tkeep SHALL be all ones on beats 0..N-2; on beat N-1 its low ceil(((DATA_WIDTH+16)-(N-1)*AXIS_DATA_WIDTH)/8) bits SHALL be 1 and the rest 0.
REQ-017 tlast SHALL be 1 only on beat N-1; N=1 makes beat 0 the last beat.
REQ-018 The FSM SHALL have states IDLE and SEND.
REQ-019 In IDLE with en=1, the block SHALL grant one channel with s_valid=1 by round-robin, searching from the channel after the last granted one; after reset the search SHALL start at channel 0.
REQ-020 s_ready[i] SHALL be combinational and equal (state==IDLE) & en & grant[i]; at most one bit SHALL be high.
REQ-021 On the accept cycle the block SHALL latch the record, channel and sequence number, and go to SEND; beat 0 SHALL drive tvalid=1 in the next cycle.
REQ-022 In SEND, tdata, tkeep and tlast SHALL stay stable while tvalid=1 and tready=0; each cycle with tvalid&tready SHALL advance one beat.
REQ-023 When beat N-1 is accepted, the FSM SHALL return to IDLE with tvalid=0, and the channel's sequence number SHALL increment modulo 256.
REQ-024 There SHALL be one idle cycle between packets, so a new accept is possible in the first IDLE cycle.
REQ-025 Deasserting en during SEND SHALL NOT abort the packet.
REQ-026 seq_clr SHALL zero all counters in the next cycle; if it coincides with a packet completion, the clear SHALL win; a packet already latched SHALL keep its latched sequence number.
REQ-027 s_valid falling while not granted SHALL have no effect; a channel's s_data SHALL only be sampled on its accept cycle.
REQ-028 busy SHALL equal (state==SEND); cur_ch SHALL hold the last latched channel.

Reset
REQ-029 Asserting m_axis_c2h_aresetn low SHALL immediately force IDLE; tvalid, tlast, busy, s_ready, cur_ch and all sequence counters to 0; tkeep and tdata to 0; round-robin pointer to channel 0.
REQ-030 Reset during SEND SHALL abandon the packet with no further beats after release.

Verification
REQ-031 Defaults, ch0 valid with record=0x..AB, tready=1 -> 8 beats; beat0[15:0]=0x0000, beat0[23:16]=0xAB; beat7 tkeep=0x3FFF_FFFF_FFFF_FFFF with tlast=1; ch0 seq becomes 1.
REQ-032 Both channels continuously valid -> packets alternate ch0, ch1, ch0 ...; hdr[11:8] alternates; each channel's seq goes 0,1,2; one idle cycle between packets.
REQ-033 tready toggles 1/0 every cycle -> beat data stable while stalled; exactly 8 handshakes per packet; no beat is lost or duplicated.
REQ-034 256 packets on ch1 then one more -> seq field wraps from 255 to 0; seq_clr pulsed at packet completion -> next seq is 0.
REQ-035 Reset asserted at beat 3 -> tvalid=0 immediately; after release, ch0 valid -> a fresh packet with seq=0 and channel=0.
REQ-036 en=0 with s_valid=all ones -> s_ready=0 and no tvalid; en dropped mid-packet -> the packet completes.
